bcd_serial_accumulator: RTL and testbench
=========================================

# bcd_serial_accumulator

Parametrised BCD accumulator that adds or subtracts one BCD operand per transaction into a stored total. Digits are processed serially, one per clock, least-significant first, to keep logic small for wide counters. Results saturate at all-nines or zero. Used for game score and counter bookkeeping, replacing wide combinational BCD adder chains where a few cycles of latency are acceptable.

## Interface
- DIGITS_COUNT, 4, number of BCD digits in the operand and accumulator; must be ≥ 1.

- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of the accumulator and sticky flag; highest priority.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept an operand.
- in_value  in  DIGITS_COUNT*4  BCD operand, digit 0 in bits [3:0].
- in_sub  in  1  0 = add, 1 = subtract; sampled with the operand.
- acc  out  DIGITS_COUNT*4  committed BCD total.
- done  out  1  one-cycle pulse in the cycle after a result commits.
- saturated  out  1  sticky; set when any commit saturates.

## Operation
- States: IDLE, RUN, COMMIT. `in_ready` = (state == IDLE).
- Accept: when `in_valid && in_ready` at an edge, the block:
  - latches the operand and `in_sub`;
  - copies `acc` into the working register;
  - sets digit index 0 and `carry = in_sub`;
  - enters RUN.
- Operand digits > 9 are treated as 9 at latch time.
- RUN, each edge, for digit `i`:
  - `b' = in_sub ? 9 - b[i] : b[i]`;
  - `s = work[i] + b' + carry`, with 5-bit intermediate;
  - if `s > 9`: `digit = s - 10`, `carry = 1`; otherwise `digit = s`, `carry = 0`;
  - write the digit into `work[i]`.
  - When `i == DIGITS_COUNT-1`, go to COMMIT; otherwise increment `i`.
- COMMIT, one edge, then IDLE:
  - add with final carry = 1: `acc` = all 9s, `saturated` ← 1;
  - subtract with final carry = 0 (borrow): `acc` = 0, `saturated` ← 1;
  - otherwise `acc = work`.
  - `done` is registered high for the next cycle.
- `acc` does not change during RUN; partial results are never visible.
- `clear` high at an edge, in any state:
  - `acc` ← 0, `saturated` ← 0, state ← IDLE, `done` ← 0;
  - any in-flight operation is discarded;
  - an operand offered on the same edge is not accepted.
- `in_valid` while busy is ignored. The operand must be held until the handshake; that is the source's responsibility.
- Reset values: `acc` = 0, `saturated` = 0, `done` = 0, state IDLE (so `in_ready` = 1), work = 0, index = 0.
- Reset asserted mid-operation aborts immediately to reset values.

## Timing
- Accept edge E0. Digit edges E1..E_D (D = DIGITS_COUNT). Commit edge E_{D+1}.
- `in_ready` is low for D+1 cycles after E0.
- `done` is high and `acc` is new during the cycle after E_{D+1}.
- `in_ready` is high in the `done` cycle, so back-to-back operands can be accepted there.
- Throughput: one operation per D+2 cycles.
- With D = 1, there is one RUN edge, then COMMIT.

## Test plan
All scenarios use DIGITS_COUNT = 4.
- Reset: hold `rst_n` = 0 with random inputs -> `acc` = 0x0000, `in_ready` = 1, `done` = 0, `saturated` = 0.
  - Release reset, then add 0x1234 -> `in_ready` low 5 cycles, `done` pulse 1 cycle, `acc` = 0x1234 exactly 5 edges after accept.
- Carry ripple: `acc` = 0x1234, add 0x0766 -> `acc` = 0x2000.
  - Then subtract 0x0001 -> `acc` = 0x1999, `saturated` = 0.
- Saturation:
  - `acc` = 0x9990 add 0x0015 -> `acc` = 0x9999, `saturated` = 1.
  - `clear` -> 0x0000 and flag 0.
  - Add 0x0005, then subtract 0x0007 -> `acc` = 0x0000, `saturated` = 1.
- Invalid digits: `acc` = 0, add 0x00AF -> treated as 0x0099, `acc` = 0x0099.
- Clear mid-run: accept add 0x5000, then assert `clear` 2 cycles later -> `acc` = 0x0000, no `done`, `in_ready` = 1 the next cycle.
  - Async reset mid-RUN gives the same result.
- Backpressure: hold `in_valid` with a new operand through the busy period -> accepted only in the `done` cycle, exactly once.
  - Two back-to-back adds of 0x0001 -> `acc` = 0x0002 after 12 cycles.

Source files
------------

// File: rtl/bcd_serial_accumulator.sv
// ============================================================================
// Module      : bcd_serial_accumulator
// Description : BCD accumulator that adds or subtracts one operand per
//               transaction, one digit per clock, saturating at 0 / all-nines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_accumulator #(
  parameter int DIGITS_COUNT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGITS_COUNT*4-1:0] in_value,
  input  logic                      in_sub,
  output logic [DIGITS_COUNT*4-1:0] acc,
  output logic                      done,
  output logic                      saturated
);

  localparam int W     = DIGITS_COUNT * 4;
  localparam int IDX_W = (DIGITS_COUNT > 1) ? $clog2(DIGITS_COUNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS_COUNT - 1);
  localparam logic [W-1:0]     ALL_NINES = {DIGITS_COUNT{4'h9}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     work_q, work_d;
  logic [W-1:0]     operand_q, operand_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;

  logic [W-1:0]     operand_clean;
  logic [3:0]       work_digit;
  logic [3:0]       operand_digit;
  logic [3:0]       operand_adj;
  logic [4:0]       digit_sum;
  logic [3:0]       digit_out;

  // Non-decimal operand digits are clamped to 9 before they are stored.
  always_comb begin
    operand_clean = '0;
    for (int i = 0; i < DIGITS_COUNT; i++) begin
      operand_clean[i*4 +: 4] = (in_value[i*4 +: 4] > 4'd9) ? 4'd9 : in_value[i*4 +: 4];
    end
  end

  // Subtraction is nines-complement plus an initial carry of one.
  always_comb begin
    work_digit    = work_q[{idx_q, 2'b00} +: 4];
    operand_digit = operand_q[{idx_q, 2'b00} +: 4];
    operand_adj   = sub_q ? (4'd9 - operand_digit) : operand_digit;
    digit_sum     = {1'b0, work_digit} + {1'b0, operand_adj} + {4'b0000, carry_q};
    digit_out     = (digit_sum > 5'd9) ? 4'(digit_sum - 5'd10) : digit_sum[3:0];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    work_d    = work_q;
    operand_d = operand_q;
    idx_d     = idx_q;
    sub_d     = sub_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    sat_d     = sat_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          operand_d = operand_clean;
          sub_d     = in_sub;
          work_d    = acc_q;
          idx_d     = '0;
          carry_d   = in_sub;
          state_d   = RUN;
        end
      end
      RUN: begin
        work_d[{idx_q, 2'b00} +: 4] = digit_out;
        carry_d = (digit_sum > 5'd9);
        if (idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      COMMIT: begin
        // Carry out on add is overflow; no carry out on subtract is a borrow.
        if (!sub_q && carry_q) begin
          acc_d = ALL_NINES;
          sat_d = 1'b1;
        end else if (sub_q && !carry_q) begin
          acc_d = '0;
          sat_d = 1'b1;
        end else begin
          acc_d = work_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      acc_d   = '0;
      sat_d   = 1'b0;
      done_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      work_q    <= '0;
      operand_q <= '0;
      idx_q     <= '0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      operand_q <= operand_d;
      idx_q     <= idx_d;
      sub_q     <= sub_d;
      carry_q   <= carry_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign acc       = acc_q;
  assign done      = done_q;
  assign saturated = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_accumulator.sv
// ============================================================================
// Module      : tb_bcd_serial_accumulator
// Description : Self-checking bench with an integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_accumulator;

  localparam int D    = 4;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sub = 1'b0;
  logic [15:0] in_value = 16'h0000;
  logic        in_ready;
  logic [15:0] acc;
  logic        done;
  logic        saturated;

  int checks = 0;
  int errors = 0;

  bcd_serial_accumulator #(.DIGITS_COUNT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_sub    (in_sub),
    .acc       (acc),
    .done      (done),
    .saturated (saturated)
  );

  always #5 clk = ~clk;

  // Reference model: decimal integers and a busy countdown.
  int m_acc = 0;
  bit m_sat = 0;
  bit m_done = 0;
  int m_busy = 0;
  int m_pend = 0;
  bit m_pend_sat = 0;
  int m_accepts = 0;
  int m_r;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = 16'h0000;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int op_val(input logic [15:0] v);
    int r;
    int p;
    int d;
    r = 0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(v[i*4 +: 4]);
      if (d > 9) d = 9;
      r = r + d * p;
      p = p * 10;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc = 0; m_sat = 0; m_done = 0; m_busy = 0;
    end else if (clear) begin
      m_acc = 0; m_sat = 0; m_done = 0; m_busy = 0;
    end else begin
      m_done = 0;
      if (m_busy > 0) begin
        m_busy = m_busy - 1;
        if (m_busy == 0) begin
          m_acc = m_pend;
          if (m_pend_sat) m_sat = 1;
          m_done = 1;
        end
      end else if (in_valid) begin
        m_r = in_sub ? (m_acc - op_val(in_value)) : (m_acc + op_val(in_value));
        m_pend_sat = 0;
        if (m_r > MAXV) begin m_r = MAXV; m_pend_sat = 1; end
        if (m_r < 0)    begin m_r = 0;    m_pend_sat = 1; end
        m_pend = m_r;
        m_busy = D + 1;
        m_accepts = m_accepts + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("in_ready",  {31'd0, in_ready},  {31'd0, (m_busy == 0)});
    check("acc",       {16'd0, acc},       {16'd0, to_bcd(m_acc)});
    check("done",      {31'd0, done},      {31'd0, m_done});
    check("saturated", {31'd0, saturated}, {31'd0, m_sat});
  end

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=event at %0t", name, $time);
  endtask

  task automatic do_op(input logic [15:0] v, input logic s, output int low_cycles);
    int n;
    n = 0;
    low_cycles = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin timeout("ready_wait"); return; end
    in_valid = 1'b1; in_value = v; in_sub = s;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      if (!in_ready) low_cycles++;
      @(negedge clk);
      n++;
    end
    if (!done) timeout("done_wait");
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  int lc;
  int acc0;
  int n;

  initial begin
    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); in_value = 16'($urandom); in_sub = 1'($urandom);
    end
    check("rst_acc", {16'd0, acc}, 32'h0000);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    in_valid = 1'b0; in_sub = 1'b0; in_value = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;

    do_op(16'h1234, 1'b0, lc);
    check("first_ready_low", lc, 5);
    check("first_acc", {16'd0, acc}, 32'h1234);
    check("first_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);

    do_op(16'h0766, 1'b0, lc);
    check("ripple_add", {16'd0, acc}, 32'h2000);
    do_op(16'h0001, 1'b1, lc);
    check("ripple_sub", {16'd0, acc}, 32'h1999);
    check("ripple_sat", {31'd0, saturated}, 32'd0);

    pulse_clear();
    do_op(16'h9990, 1'b0, lc);
    do_op(16'h0015, 1'b0, lc);
    check("sat_hi_acc", {16'd0, acc}, 32'h9999);
    check("sat_hi_flag", {31'd0, saturated}, 32'd1);
    pulse_clear();
    check("clear_acc", {16'd0, acc}, 32'h0000);
    check("clear_flag", {31'd0, saturated}, 32'd0);
    do_op(16'h0005, 1'b0, lc);
    do_op(16'h0007, 1'b1, lc);
    check("sat_lo_acc", {16'd0, acc}, 32'h0000);
    check("sat_lo_flag", {31'd0, saturated}, 32'd1);

    pulse_clear();
    do_op(16'h00AF, 1'b0, lc);
    check("invalid_digits", {16'd0, acc}, 32'h0099);

    // Clear two cycles after accept.
    @(negedge clk);
    in_valid = 1'b1; in_value = 16'h5000; in_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("midclear_acc", {16'd0, acc}, 32'h0000);
    check("midclear_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midclear_nodone", {31'd0, done}, 32'd0);
    end

    // Asynchronous reset in the middle of RUN.
    do_op(16'h0042, 1'b0, lc);
    @(negedge clk);
    in_valid = 1'b1; in_value = 16'h5000; in_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc", {16'd0, acc}, 32'h0000);
    check("arst_ready", {31'd0, in_ready}, 32'd1);
    check("arst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure: operand held through the busy period, two adds of 1.
    @(negedge clk);
    acc0 = m_accepts;
    in_valid = 1'b1; in_value = 16'h0001; in_sub = 1'b0;
    @(negedge clk);
    n = 1;
    while (n < 12) begin
      if (n == 11) check("b2b_mid_acc", {16'd0, acc}, 32'h0001);
      if (in_ready) begin
        @(negedge clk);
        in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      n++;
    end
    check("b2b_acc", {16'd0, acc}, 32'h0002);
    check("b2b_accepts", m_accepts - acc0, 2);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      in_sub   = 1'($urandom);
      in_value = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom);
      clear    = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    in_valid = 1'b0;
    clear = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
